// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential RV32M multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mul_state_e;

    localparam int unsigned MUL_WIDTH   = 32;
    localparam int unsigned MUL_LATENCY = MUL_WIDTH + 2;

endpackage

// File: rtl/mul_seq_if.sv
// Request/response bundle between the execute stage and the multiplier.
interface mul_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_rs1;
    logic [WIDTH-1:0] i_rs2;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_result;

    modport master (
        output i_start, i_op, i_rs1, i_rs2,
        input  o_busy, o_valid, o_result
    );

    modport slave (
        input  i_start, i_op, i_rs1, i_rs2,
        output o_busy, o_valid, o_result
    );
endinterface

// File: rtl/mul_seq_cla.sv
// Carry-lookahead adder built from 4-bit lookahead groups; WIDTH must be a multiple of 4.
module cla #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int unsigned NGRP = WIDTH / 4;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_c;
    logic [NGRP:0]    w_gc;

    assign w_g     = i_a & i_b;
    assign w_p     = i_a ^ i_b;
    assign w_gc[0] = i_cin;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        localparam int unsigned BASE = 4 * k;
        assign w_c[BASE]   = w_gc[k];
        assign w_c[BASE+1] = w_g[BASE] | (w_p[BASE] & w_gc[k]);
        assign w_c[BASE+2] = w_g[BASE+1] | (w_p[BASE+1] & w_g[BASE])
                           | (w_p[BASE+1] & w_p[BASE] & w_gc[k]);
        assign w_c[BASE+3] = w_g[BASE+2] | (w_p[BASE+2] & w_g[BASE+1])
                           | (w_p[BASE+2] & w_p[BASE+1] & w_g[BASE])
                           | (w_p[BASE+2] & w_p[BASE+1] & w_p[BASE] & w_gc[k]);
        assign w_gc[k+1]   = w_g[BASE+3] | (w_p[BASE+3] & w_c[BASE+3]);
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_gc[NGRP];
endmodule

// File: rtl/mul_seq.sv
// Iterative shift-and-add RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Define MUL_SIGNED_EN for signed operand handling; otherwise all ops are unsigned.
module mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    mul_seq_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_FIX  = FIX;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;

    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

`ifdef MUL_SIGNED_EN
    logic w_sign1;
    logic w_sign2;
    logic r_neg;

    assign w_sign1 = bus.i_rs1[WIDTH-1] &
                     ((bus.i_op == MULH) || (bus.i_op == MULHSU));
    assign w_sign2 = bus.i_rs2[WIDTH-1] & (bus.i_op == MULH);
    assign w_mag1  = w_sign1 ? (~bus.i_rs1 + WIDTH'(1)) : bus.i_rs1;
    assign w_mag2  = w_sign2 ? (~bus.i_rs2 + WIDTH'(1)) : bus.i_rs2;
    assign {w_fix_hi, w_fix_lo} = r_neg ? (~{r_hi, r_lo} + (2*WIDTH)'(1)) : {r_hi, r_lo};
`else
    assign w_mag1 = bus.i_rs1;
    assign w_mag2 = bus.i_rs2;
    assign {w_fix_hi, w_fix_lo} = {r_hi, r_lo};
`endif

    assign w_addend = r_lo[0] ? r_mcand : '0;

    cla #(
        .WIDTH (WIDTH)
    ) u_cla (
        .i_a    (r_hi),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_mcand  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
`ifdef MUL_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_op    <= bus.i_op;
                        r_mcand <= w_mag1;
                        r_hi    <= '0;
                        r_lo    <= w_mag2;
                        r_cnt   <= '0;
`ifdef MUL_SIGNED_EN
                        r_neg   <= w_sign1 ^ w_sign2;
`endif
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Carry-out becomes the new MSB of the shifted accumulator.
                    r_hi  <= {w_cout, w_sum[WIDTH-1:1]};
                    r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi     <= w_fix_hi;
                    r_lo     <= w_fix_lo;
                    r_result <= (r_op == MUL) ? w_fix_lo : w_fix_hi;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    r_valid <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_busy   = (r_state != ST_IDLE);
    assign bus.o_valid  = r_valid;
    assign bus.o_result = r_result;
endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: arithmetic/timeline model plus directed literal vectors.
module tb_mul_seq;
    import mul_pkg::*;

    localparam int LAT = MUL_LATENCY;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mul_seq_if #(.WIDTH(32)) bus ();

    mul_seq #(
        .WIDTH (32)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product straight from the RV32M definition.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic        s1;
        logic        s2;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
`ifdef MUL_SIGNED_EN
        s1 = (op == 2'b01) || (op == 2'b10);
        s2 = (op == 2'b01);
`else
        s1 = 1'b0;
        s2 = 1'b0;
`endif
        ea = s1 ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s2 ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Timeline model: age counts edges since accept.
    logic        m_active  = 1'b0;
    int          m_age     = 0;
    logic [31:0] m_result  = '0;
    logic [31:0] m_pending = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_result <= '0;
        end else begin
            if (m_active && m_age == LAT - 2) m_result <= m_pending;
            if ((!m_active || m_age == LAT) && bus.i_start) begin
                m_active  <= 1'b1;
                m_age     <= 0;
                m_pending <= model(bus.i_op, bus.i_rs1, bus.i_rs2);
            end else if (m_active) begin
                if (m_age == LAT) m_active <= 1'b0;
                else m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", {31'b0, bus.o_busy}, {31'b0, m_active && (m_age <= LAT - 1)});
        check("valid", {31'b0, bus.o_valid}, {31'b0, m_active && (m_age == LAT)});
        check("result", bus.o_result, m_result);
    end

    // Issue one op at the current negedge; optionally inject ignored starts at edges 5 and 33.
    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit inject, input string name);
        int cycles = 0;
        bit got    = 0;
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_rs1   = a;
        bus.i_rs2   = b;
        while (!got && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (inject && (cycles == 5 || cycles == 33)) begin
                bus.i_start = 1'b1;
                bus.i_op    = 2'b11;
                bus.i_rs1   = 32'hFFFF_FFFF;
                bus.i_rs2   = 32'hFFFF_FFFF;
            end else begin
                bus.i_start = 1'b0;
            end
            if (bus.o_valid) got = 1;
        end
        bus.i_start = 1'b0;
        check({name, "_done"}, {31'b0, got}, 32'd1);
        check({name, "_lat"}, cycles - 1, LAT);
        check({name, "_res"}, bus.o_result, exp);
    endtask

    initial begin
        int vseen;
        bus.i_start = 1'b0;
        bus.i_op    = 2'b00;
        bus.i_rs1   = '0;
        bus.i_rs2   = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'b0, bus.o_busy}, 32'd0);
        check("rst_valid", {31'b0, bus.o_valid}, 32'd0);
        check("rst_result", bus.o_result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(2'b00, 32'd7, 32'd6, 32'h0000_002A, 0, "mul7x6");
        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, "mul_ff");
        run(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_ff");
`ifdef MUL_SIGNED_EN
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, "mulh_ff");
        run(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_ff");
        run(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 0, "mulh_m1x1");
`else
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulh_ff");
        run(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhsu_ff");
        run(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, "mulh_m1x1");
`endif
        run(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh_min");
        run(2'b00, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1, "ignore");
        run(2'b00, 32'h0000_0100, 32'h0000_0100, 32'h0001_0000, 0, "b2b");

        // Reset in the middle of CALC.
        bus.i_start = 1'b1;
        bus.i_op    = 2'b00;
        bus.i_rs1   = 32'd9;
        bus.i_rs2   = 32'd9;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, bus.o_busy}, 32'd0);
        check("arst_valid", {31'b0, bus.o_valid}, 32'd0);
        check("arst_result", bus.o_result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_valid) vseen++;
        end
        check("no_valid_after_rst", vseen, 32'd0);
        run(2'b00, 32'd3, 32'd5, 32'h0000_000F, 0, "mul3x5");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative shift-and-add multiplier implementing the RV32M multiply group (MUL, MULH, MULHSU, MULHU). It sits downstream of the execute-stage operand muxes and consumes the team's 32-bit carry-lookahead adder once per cycle as its accumulate datapath. It adds multi-cycle M-extension support without widening the single-cycle ALU critical path. The core stalls on `o_busy` and captures `o_result` on the `o_valid` pulse.

## Interface
- `WIDTH`, default 32: operand and result width.
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_start`  in  1  request; sampled only in IDLE.
- `i_op`  in  2  operation, equal to funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `i_rs1`  in  WIDTH  multiplicand, latched on accept.
- `i_rs2`  in  WIDTH  multiplier, latched on accept.
- `o_busy`  out  1  high whenever state is not IDLE.
- `o_valid`  out  1  one-cycle pulse; `o_result` is valid during it.
- `o_result`  out  WIDTH  low word for MUL, high word otherwise.
- Single clock `i_clk`. `i_rst_n` is asynchronous and active-low.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE with `i_start`=1 (accept edge):
  - latch the op;
  - compute the sign of each operand per op (rs1 signed for MULH/MULHSU, rs2 signed for MULH only);
  - store magnitudes in mcand/mplier;
  - set neg = sign1 XOR sign2;
  - clear the 2·WIDTH accumulator {hi, lo}, with lo loaded with the mplier magnitude;
  - set the counter to 0 and go to CALC.
- CALC, one step per cycle:
  - adder computes hi + (lo[0] ? mcand : 0) with Cin=0, giving {cout, sum};
  - then {hi, lo} ← {cout, sum, lo} >> 1;
  - counter++; after step WIDTH−1, go to FIX.
- FIX:
  - if neg, {hi, lo} ← two's complement of {hi, lo};
  - `o_result` ← lo for MUL, hi otherwise;
  - go to DONE.
- DONE: `o_valid`=1 for one cycle, then go to IDLE.
- `i_start` in CALC, FIX or DONE is ignored; there is no queuing.
- `o_result` holds its value until the next FIX.
- Magnitude of the most negative operand (0x80000000) is 0x80000000 unsigned; no overflow.
- Reset (any time, including mid-CALC): state IDLE, `o_busy`=0, `o_valid`=0, `o_result`=0, accumulator and counter 0. The in-flight operation is discarded.

## Timing
- Counting the accept edge as edge 0:
  - CALC occupies edges 1..WIDTH;
  - FIX occupies edge WIDTH+1;
  - DONE (state register) is entered at edge WIDTH+2, and `o_valid` is high during the following cycle.
- Latency is WIDTH+2 edges from accept to `o_valid`: 34 for WIDTH=32.
- `o_busy` rises on edge 1 and falls on the edge that leaves DONE.
- Earliest next accept is the edge after `o_valid` drops: back-to-back throughput is one result per WIDTH+3 cycles.
- Outputs are registered. There is no combinational path from the inputs to `o_valid` or `o_busy`.

## Configuration
- `MUL_SIGNED_EN` defined: full signed handling per `i_op`, including the sign-magnitude conversion and the FIX negation.
- `MUL_SIGNED_EN` undefined:
  - both sign flags are forced to 0, so MULH and MULHSU behave as MULHU and MUL is unchanged;
  - the negation logic is not built;
  - FIX still takes one cycle, so latency is identical in both configurations.

## Structure
- The shared package `mul_pkg` holds:
  - the `mul_op_e` enum (MUL=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11);
  - the `mul_state_e` enum (IDLE, CALC, FIX, DONE);
  - the `MUL_LATENCY` = WIDTH+2 constant, used by the bench.
- One sub-module: the existing carry-lookahead adder `cla` #(WIDTH), instantiated once as the accumulate adder (A=hi, B=gated mcand, Cin=0).
- Counter width is $clog2(WIDTH).

## Test plan
- MUL 7 × 6 → `o_result`=0x0000002A, with `o_valid` exactly 34 edges after accept and `o_busy` high from edges 1 to 34.
- 0xFFFFFFFF × 0xFFFFFFFF (MUL, MULHU, MULH, MULHSU):
  - MUL → 0x00000001;
  - MULHU → 0xFFFFFFFE;
  - MULH → 0x00000000;
  - MULHSU → 0xFFFFFFFF.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULH 0xFFFFFFFF × 0x00000001 → 0xFFFFFFFF.
- `i_start` pulsed with different operands at edges 5 and 33 of a running operation → ignored, first result intact. A new start on the edge after `o_valid` drops → accepted, correct result.
- `i_rst_n` low at edge 10 of CALC → all outputs 0 immediately (asynchronously), and no `o_valid` follows. After release, MUL 3 × 5 → 0x0000000F.
- `MUL_SIGNED_EN` undefined: MULH 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE, with latency still 34.
